if_prefetch_queue: RTL and testbench
====================================

// Module: if_prefetch_queue
// PURPOSE
//  Instruction-fetch front end sitting directly upstream of decode in pipeline_cpu_top.
//  Owns the fetch PC and drives the instruction-memory read port (rd_insn_en/pc).
//  Captures the combinational insn return into a small prefetch FIFO and presents
//  {pc, insn} pairs to the ID stage with a valid/ready handshake.
//  Flushes on branch/jump redirect.
// PARAMETERS
//  PC_WIDTH    32  fetch address width (matches `PC_WIDTH)
//  WORD_WIDTH  32  instruction width (matches `WORD_WIDTH)
//  DEPTH       4   queue entries; power of two, >= 2
//  RESET_PC    0   fetch address loaded on reset
// PORTS
//  clk          in   1           system clock; all state on posedge
//  rst          in   1           reset: one clock; reset is asynchronous and active-high
//  cpu_en       in   1           fetch enable; 0 = no new memory reads
//  rd_insn_en   out  1           instruction-memory read strobe
//  pc           out  PC_WIDTH    fetch address, word aligned
//  insn         in   WORD_WIDTH  memory data, valid in the same cycle as rd_insn_en
//  redirect_en  in   1           branch/jump taken: flush queue, reload fetch PC
//  redirect_pc  in   PC_WIDTH    new fetch target; bits [1:0] ignored (forced 0)
//  id_valid     out  1           head entry available to decode
//  id_ready     in   1           decode accepts head this cycle
//  id_pc        out  PC_WIDTH    PC of head entry
//  id_insn      out  WORD_WIDTH  instruction of head entry
//  q_count      out  clog2(DEPTH)+1  occupied entries (debug/perf)
// BEHAVIOUR
//  Reset values: fetch_pc=RESET_PC, count=0, rd/wr ptr=0, rd_insn_en=0, id_valid=0,
//   id_pc=0, id_insn=0, q_count=0. Async assert clears all state mid-operation,
//   including a partly drained queue; first fetch follows the first posedge after release.
//  pc = fetch_pc (registered).
//  rd_insn_en = cpu_en & ~full & ~redirect_en (combinational; no dependency on id_ready).
//  push = rd_insn_en: store {fetch_pc, insn}; fetch_pc <= fetch_pc+4, wrapping mod 2^PC_WIDTH.
//  pop = id_valid & id_ready; id_valid = (count != 0).
//  id_pc/id_insn = storage[rd_ptr]; when empty, drive 0.
//  Latency: insn fetched in cycle N appears on id_insn in cycle N+1 if queue empty.
//  Push and pop in the same cycle: count unchanged; both pointers advance.
//  Full: no push, even if pop occurs that cycle; fetch resumes the cycle after count<DEPTH.
//  Empty with id_ready=1: no pop; pointers unchanged.
//  Pointers wrap modulo DEPTH.
//  redirect_en: count<=0, rd_ptr<=wr_ptr, fetch_pc<={redirect_pc[PC_WIDTH-1:2],2'b00};
//   no push, pop ignored that cycle. Redirect has priority over everything except reset.
//  cpu_en=0: fetch_pc holds, no push; queued entries keep draining to decode.
//   A redirect still applies while cpu_en=0.
//  Control view (derived from count): EMPTY (count=0), PARTIAL, FULL (count=DEPTH);
//   transitions only via push/pop/redirect as above.
// STRUCTURE
//  Shared define file: `PC_WIDTH, `WORD_WIDTH, `INSN_STEP (4), RESET_PC default.
//  One sub-module: if_queue_fifo.
//   Sync FIFO with DEPTH x (PC_WIDTH+WORD_WIDTH) storage, wr/rd ptrs, count, flush input.
//   Top level holds fetch_pc, read-strobe logic and redirect handling.
// TESTING
//  1. Reset release, cpu_en=1, id_ready=1, mem[i]=0x100+i -> pc 0,4,8,...
//     id_insn 0x100,0x101,... one per cycle, each one cycle after its fetch.
//  2. id_ready=0, DEPTH=4 -> exactly 4 reads (pc 0..C), rd_insn_en=0, q_count=4;
//     raise id_ready -> pops in order; fetch resumes at pc=0x10 one cycle after first pop.
//  3. Queue holding 3 entries, redirect_en with redirect_pc=0x42 -> next cycle q_count=0,
//     id_valid=0, pc=0x40; first delivered insn = mem[0x40>>2].
//  4. Push and pop every cycle at q_count=2 -> q_count stays 2 over 20 cycles;
//     ptr wrap is invisible in id_insn order.
//  5. cpu_en dropped with 2 queued -> both delivered, then id_valid=0; pc frozen.
//  6. rst asserted mid-stream, asynchronously between edges -> all outputs 0 immediately;
//     pc=RESET_PC after release.
//     RESET_PC=0xFFFFFFF8 -> pc wraps 0xFFFFFFFC then 0x0.

Source files
------------

// File: rtl/if_prefetch_queue_pkg.sv
// Shared widths, fetch step and the queue occupancy view for the fetch front end.
package if_prefetch_queue_pkg;

    localparam int unsigned PC_WIDTH_DFLT   = 32;
    localparam int unsigned WORD_WIDTH_DFLT = 32;
    localparam int unsigned INSN_STEP       = 4;
    localparam logic [31:0] RESET_PC_DFLT   = 32'h0000_0000;

    // Occupancy view of the prefetch queue, derived purely from its count
    typedef enum logic [1:0] {
        QEmpty,
        QPartial,
        QFull
    } q_state_e;

    function automatic q_state_e q_state_of(input int unsigned count, input int unsigned depth);
        if (count == 0) begin
            return QEmpty;
        end
        if (count >= depth) begin
            return QFull;
        end
        return QPartial;
    endfunction

endpackage

// File: rtl/if_queue_fifo.sv
// Small synchronous FIFO holding {pc, insn} pairs; flush discards all entries in one cycle.
module if_queue_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Flush wins over both ports; a full queue refuses pushes, an empty one ignores pops
    assign do_push = push & ~flush & (count != CW'(DEPTH));
    assign do_pop  = pop & ~flush & (count != '0);

    assign rdata = (count != '0) ? storage[rd_ptr] : '0;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at a power-of-two depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only observed while count is non-zero, so no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction fetch front end: owns the fetch PC, strobes instruction memory and queues
// returned {pc, insn} pairs for decode. A redirect flushes the queue and reloads the PC.
module if_prefetch_queue
    import if_prefetch_queue_pkg::*;
#(
    parameter int unsigned           PC_WIDTH   = PC_WIDTH_DFLT,
    parameter int unsigned           WORD_WIDTH = WORD_WIDTH_DFLT,
    parameter int unsigned           DEPTH      = 4,
    parameter logic [PC_WIDTH-1:0]   RESET_PC   = PC_WIDTH'(RESET_PC_DFLT)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_en,
    output logic                      rd_insn_en,
    output logic [PC_WIDTH-1:0]       pc,
    input  logic [WORD_WIDTH-1:0]     insn,
    input  logic                      redirect_en,
    input  logic [PC_WIDTH-1:0]       redirect_pc,
    output logic                      id_valid,
    input  logic                      id_ready,
    output logic [PC_WIDTH-1:0]       id_pc,
    output logic [WORD_WIDTH-1:0]     id_insn,
    output logic [$clog2(DEPTH):0]    q_count
);

    localparam int unsigned EW = PC_WIDTH + WORD_WIDTH;

    logic [PC_WIDTH-1:0] fetch_pc;
    logic [EW-1:0]       head;
    logic                full;
    logic                pop;
    q_state_e            q_state;

    assign q_state = q_state_of(32'(q_count), DEPTH);
    assign full    = (q_state == QFull);

    // Read strobe is independent of id_ready; it is held low while reset is asserted
    assign rd_insn_en = ~rst & cpu_en & ~full & ~redirect_en;
    assign pop        = id_valid & id_ready & ~redirect_en;
    assign id_valid   = (q_state != QEmpty);
    assign pc         = fetch_pc;
    assign id_pc      = head[EW-1 -: PC_WIDTH];
    assign id_insn    = head[WORD_WIDTH-1:0];

    // Fetch PC: redirect takes priority, otherwise advance one word per issued read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_en) begin
            fetch_pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00};
        end else if (rd_insn_en) begin
            fetch_pc <= fetch_pc + PC_WIDTH'(INSN_STEP);
        end
    end

    if_queue_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_en),
        .push  (rd_insn_en),
        .wdata ({fetch_pc, insn}),
        .pop   (pop),
        .rdata (head),
        .count (q_count)
    );

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue with a scoreboard of expected {pc, insn} pairs.
module tb_if_prefetch_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_en = 1'b0;
    logic        rd_insn_en;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_insn;
    logic [2:0]  q_count;

    // Second instance exercising a reset PC near the top of the address space
    logic        cpu_en2 = 1'b0;
    logic        rd_insn_en2;
    logic [31:0] pc2;
    logic        id_valid2;
    logic [31:0] id_pc2;
    logic [31:0] id_insn2;
    logic [2:0]  q_count2;

    int checks = 0;
    int errors = 0;

    logic [63:0] sb [$];
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'h100 + (a >> 2);
    endfunction

    assign insn = mem(pc);

    if_prefetch_queue #(
        .PC_WIDTH   (32),
        .WORD_WIDTH (32),
        .DEPTH      (DEPTH),
        .RESET_PC   (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_en      (cpu_en),
        .rd_insn_en  (rd_insn_en),
        .pc          (pc),
        .insn        (insn),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_pc       (id_pc),
        .id_insn     (id_insn),
        .q_count     (q_count)
    );

    if_prefetch_queue #(
        .PC_WIDTH   (32),
        .WORD_WIDTH (32),
        .DEPTH      (DEPTH),
        .RESET_PC   (32'hFFFF_FFF8)
    ) dut2 (
        .clk         (clk),
        .rst         (rst),
        .cpu_en      (cpu_en2),
        .rd_insn_en  (rd_insn_en2),
        .pc          (pc2),
        .insn        (32'h0),
        .redirect_en (1'b0),
        .redirect_pc (32'h0),
        .id_valid    (id_valid2),
        .id_ready    (1'b1),
        .id_pc       (id_pc2),
        .id_insn     (id_insn2),
        .q_count     (q_count2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: compare at the falling edge against the model, update it, then
    // return 1ns after the rising edge so the caller can drive the next inputs.
    task automatic cycle();
        logic exp_rd;
        @(negedge clk);
        exp_rd = cpu_en && (sb.size() < DEPTH) && !redirect_en;
        chk("pc", 64'(pc), 64'(exp_pc));
        chk("rd_insn_en", 64'(rd_insn_en), 64'(exp_rd));
        chk("id_valid", 64'(id_valid), 64'(sb.size() != 0));
        chk("q_count", 64'(q_count), 64'(sb.size()));
        if (sb.size() != 0) begin
            chk("id_pc", 64'(id_pc), 64'(sb[0][63:32]));
            chk("id_insn", 64'(id_insn), 64'(sb[0][31:0]));
        end else begin
            chk("id_pc_empty", 64'(id_pc), 64'h0);
            chk("id_insn_empty", 64'(id_insn), 64'h0);
        end
        if (redirect_en) begin
            sb.delete();
            exp_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (sb.size() != 0 && id_ready) begin
                void'(sb.pop_front());
            end
            if (exp_rd) begin
                sb.push_back({exp_pc, mem(exp_pc)});
                exp_pc = exp_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            cycle();
        end
    endtask

    initial begin
        exp_pc = 32'h0;
        // Reset state while reset is held
        @(posedge clk);
        #1;
        chk("rst_pc", 64'(pc), 64'h0);
        chk("rst_rd_insn_en", 64'(rd_insn_en), 64'h0);
        chk("rst_id_valid", 64'(id_valid), 64'h0);
        chk("rst_q_count", 64'(q_count), 64'h0);
        chk("rst_pc2", 64'(pc2), 64'hFFFF_FFF8);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: streaming fetch, one insn per cycle with one cycle latency
        cpu_en   = 1'b1;
        id_ready = 1'b1;
        run(8);

        // 2: decode stalled fills the queue and stops reads, then drains in order
        id_ready = 1'b0;
        run(7);
        chk("full_q_count", 64'(q_count), 64'd4);
        id_ready = 1'b1;
        run(6);

        // 3: three queued entries, then redirect to an unaligned target
        cpu_en = 1'b0;
        run(5);
        cpu_en   = 1'b1;
        id_ready = 1'b0;
        run(3);
        chk("pre_redirect_count", 64'(q_count), 64'd3);
        redirect_en = 1'b1;
        redirect_pc = 32'h42;
        run(1);
        redirect_en = 1'b0;
        id_ready    = 1'b1;
        run(4);

        // 4: hold occupancy at two with simultaneous push and pop across pointer wraps
        cpu_en = 1'b0;
        run(4);
        cpu_en   = 1'b1;
        id_ready = 1'b0;
        run(2);
        id_ready = 1'b1;
        run(20);
        chk("steady_q_count", 64'(q_count), 64'd2);

        // 5: fetch disabled with two queued entries; they drain and the pc stays put
        cpu_en = 1'b0;
        run(4);

        // Redirect still applies while fetch is disabled
        redirect_en = 1'b1;
        redirect_pc = 32'h200;
        run(1);
        redirect_en = 1'b0;
        run(2);

        // 6: asynchronous reset mid-stream, asserted between clock edges
        cpu_en = 1'b1;
        id_ready = 1'b0;
        run(3);
        #2;
        rst = 1'b1;
        #1;
        chk("async_pc", 64'(pc), 64'h0);
        chk("async_rd_insn_en", 64'(rd_insn_en), 64'h0);
        chk("async_id_valid", 64'(id_valid), 64'h0);
        chk("async_id_pc", 64'(id_pc), 64'h0);
        chk("async_id_insn", 64'(id_insn), 64'h0);
        chk("async_q_count", 64'(q_count), 64'h0);
        sb.delete();
        exp_pc = 32'h0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        id_ready = 1'b1;
        cpu_en2  = 1'b1;
        chk("wrap_pc2_0", 64'(pc2), 64'hFFFF_FFF8);
        run(1);
        chk("wrap_pc2_1", 64'(pc2), 64'hFFFF_FFFC);
        run(1);
        chk("wrap_pc2_2", 64'(pc2), 64'h0);
        run(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
